// File: rtl/trig_scaler_pkg.sv
// trig_scaler_pkg: shared types and default widths for the trigger scaler.
//   state_e         - scaler FSM states (StIdle, StRun)
//   DefWidth        - default count/result width
//   DefPeriodWidth  - default window-length register width
//   DefHoldoffWidth - default holdoff register width
package trig_scaler_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned DefWidth        = 16;
    localparam int unsigned DefPeriodWidth  = 24;
    localparam int unsigned DefHoldoffWidth = 8;

endpackage

// File: rtl/scaler_window_timer.sv
// scaler_window_timer: window length capture and window position counter.
//   clk_i      - system clock
//   rst_i      - synchronous active-high reset
//   start_i    - idle-to-run transition this cycle; captures period_i, restarts count
//   run_i      - window is running this cycle
//   period_i   - window length minus 1
//   terminal_o - current cycle is the last cycle of the window
module scaler_window_timer #(
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    run_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    terminal_o
);

    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;

    assign terminal_o = run_i && (cnt_q == period_q);

    always_comb begin
        period_d = period_q;
        cnt_d    = '0;
        if (start_i) begin
            period_d = period_i;
        end else if (run_i) begin
            if (terminal_o) begin
                // Reload at the boundary so mid-window changes apply to the next window.
                period_d = period_i;
            end else begin
                cnt_d = cnt_q + PERIOD_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/trig_scaler.sv
// trig_scaler: counts single-cycle trigger pulses over a programmable window and
// publishes the saturated count with a one-cycle valid strobe.
//   CLK, RST    - clock and synchronous active-high reset
//   PULSE_I     - one event per high cycle
//   ENABLE_I    - run windows back to back while high
//   PERIOD_I    - window length minus 1
//   HOLDOFF_I   - dead cycles after an accepted pulse (only with SCALER_HOLDOFF_EN)
//   COUNT_O     - count of the last completed window
//   VALID_O     - strobe when COUNT_O updates
//   OVERFLOW_O  - the published count saturated
// Build option: define SCALER_HOLDOFF_EN to enable the pulse holdoff counter.
module trig_scaler
    import trig_scaler_pkg::*;
#(
    parameter int unsigned WIDTH         = DefWidth,
    parameter int unsigned PERIOD_WIDTH  = DefPeriodWidth,
    parameter int unsigned HOLDOFF_WIDTH = DefHoldoffWidth
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     PULSE_I,
    input  logic                     ENABLE_I,
    input  logic [PERIOD_WIDTH-1:0]  PERIOD_I,
    input  logic [HOLDOFF_WIDTH-1:0] HOLDOFF_I,
    output logic [WIDTH-1:0]         COUNT_O,
    output logic                     VALID_O,
    output logic                     OVERFLOW_O
);

    localparam logic [WIDTH-1:0] AccMax = '1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              win_ovf_q, win_ovf_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    logic start, run, terminal, accept, hold_ok;

    assign start  = (state_q == StIdle) && ENABLE_I;
    assign run    = (state_q == StRun) && ENABLE_I;
    assign accept = run && PULSE_I && hold_ok;

    scaler_window_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .clk_i     (CLK),
        .rst_i     (RST),
        .start_i   (start),
        .run_i     (run),
        .period_i  (PERIOD_I),
        .terminal_o(terminal)
    );

`ifdef SCALER_HOLDOFF_EN
    logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;

    assign hold_ok = (hold_q == '0);

    always_comb begin
        hold_d = hold_q;
        if (!run) begin
            // Holdoff only lives while running; leaving RUN clears it.
            hold_d = '0;
        end else if (accept) begin
            hold_d = HOLDOFF_I;
        end else if (!hold_ok) begin
            hold_d = hold_q - HOLDOFF_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_holdoff;
    assign unused_holdoff = ^HOLDOFF_I;
    assign hold_ok        = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ENABLE_I) state_d = StRun;
            StRun:   if (!ENABLE_I) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        win_ovf_d = win_ovf_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        if (accept) begin
            if (acc_q == AccMax) begin
                win_ovf_d = 1'b1;
            end else begin
                acc_d = acc_q + WIDTH'(1);
            end
        end
        // acc_d/win_ovf_d already include the terminal cycle's own pulse.
        if (terminal) begin
            count_d   = acc_d;
            ovf_d     = win_ovf_d;
            valid_d   = 1'b1;
            acc_d     = '0;
            win_ovf_d = 1'b0;
        end
        if (!run) begin
            acc_d     = '0;
            win_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            win_ovf_q <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            win_ovf_q <= win_ovf_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign COUNT_O    = count_q;
    assign VALID_O    = valid_q;
    assign OVERFLOW_O = ovf_q;

endmodule

// File: tb/tb_trig_scaler.sv
// Testbench for trig_scaler: directed scenarios plus randomized traffic, all checked
// against a window-level reference model (true event count, saturated on publish).
module tb_trig_scaler;

    localparam int W        = 4;
    localparam int PW       = 8;
    localparam int HW       = 4;
    localparam int MaxCount = 15;
`ifdef SCALER_HOLDOFF_EN
    localparam int HoldExp = 3;
`else
    localparam int HoldExp = 10;
`endif

    logic          clk;
    logic          RST;
    logic          PULSE_I;
    logic          ENABLE_I;
    logic [PW-1:0] PERIOD_I;
    logic [HW-1:0] HOLDOFF_I;
    logic [W-1:0]  COUNT_O;
    logic          VALID_O;
    logic          OVERFLOW_O;

    int n_cmp = 0;
    int n_bad = 0;

    trig_scaler #(
        .WIDTH        (W),
        .PERIOD_WIDTH (PW),
        .HOLDOFF_WIDTH(HW)
    ) dut (
        .CLK       (clk),
        .RST       (RST),
        .PULSE_I   (PULSE_I),
        .ENABLE_I  (ENABLE_I),
        .PERIOD_I  (PERIOD_I),
        .HOLDOFF_I (HOLDOFF_I),
        .COUNT_O   (COUNT_O),
        .VALID_O   (VALID_O),
        .OVERFLOW_O(OVERFLOW_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks window position and the true number of accepted events.
    bit           m_run = 0;
    int           m_pos = 0;
    int           m_len = 1;
    int           m_events = 0;
    int           m_hold = 0;
    logic [W-1:0] m_count = '0;
    logic         m_valid = 1'b0;
    logic         m_ovf = 1'b0;

    always @(posedge clk) begin
        bit acc;
        m_valid = 1'b0;
        if (RST) begin
            m_run = 0; m_pos = 0; m_events = 0; m_hold = 0;
            m_count = '0; m_ovf = 1'b0;
        end else if (!m_run) begin
            if (ENABLE_I) begin
                m_run = 1; m_pos = 0; m_events = 0; m_hold = 0;
                m_len = int'(PERIOD_I) + 1;
            end
        end else if (!ENABLE_I) begin
            m_run = 0; m_hold = 0;
        end else begin
            acc = PULSE_I && (m_hold == 0);
`ifdef SCALER_HOLDOFF_EN
            if (acc) m_hold = int'(HOLDOFF_I);
            else if (m_hold > 0) m_hold = m_hold - 1;
`endif
            if (acc) m_events = m_events + 1;
            m_pos = m_pos + 1;
            if (m_pos == m_len) begin
                m_valid = 1'b1;
                m_ovf   = (m_events > MaxCount);
                m_count = (m_events > MaxCount) ? 4'(MaxCount) : 4'(m_events);
                m_events = 0;
                m_pos    = 0;
                m_len    = int'(PERIOD_I) + 1;
            end
        end
    end

    task automatic go_idle();
        repeat (2) begin
            RST = 1'b0; ENABLE_I = 1'b0; PULSE_I = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 13; d++) begin
            RST = (d < 3); ENABLE_I = 1'b0; PULSE_I = (d >= 3);
            @(negedge clk);
            n_cmp++;
            if ({VALID_O, OVERFLOW_O, COUNT_O} !== {1'b0, 1'b0, 4'd0}) begin
                n_bad++;
                $display("FAIL reset d=%0d: got v=%b o=%b c=%0d, want v=0 o=0 c=0",
                         d, VALID_O, OVERFLOW_O, COUNT_O);
            end
        end
    endtask

    task automatic test_basic();
        logic [9:0] mask [3];
        logic       p;
        bit         exp_v;
        for (int k = 0; k < 3; k++) begin
            mask[k] = 10'h200;  // terminal-cycle pulse always present
            while ($countones(mask[k]) < 4) mask[k][$urandom_range(8, 0)] = 1'b1;
        end
        PERIOD_I = 8'd9; HOLDOFF_I = '0;
        for (int d = 0; d <= 30; d++) begin
            p = (d >= 1) ? mask[(d - 1) / 10][(d - 1) % 10] : 1'b0;
            ENABLE_I = 1'b1; PULSE_I = p;
            @(negedge clk);
            n_cmp++;
            if ({VALID_O, OVERFLOW_O, COUNT_O} !== {m_valid, m_ovf, m_count}) begin
                n_bad++;
                $display("FAIL basic_model d=%0d: got v=%b o=%b c=%0d, want v=%b o=%b c=%0d",
                         d, VALID_O, OVERFLOW_O, COUNT_O, m_valid, m_ovf, m_count);
            end
            exp_v = (d > 0) && (d % 10 == 0);
            n_cmp++;
            if (VALID_O !== exp_v || (exp_v && COUNT_O !== 4'd4)) begin
                n_bad++;
                $display("FAIL basic_window d=%0d: got v=%b c=%0d, want v=%b c=4",
                         d, VALID_O, COUNT_O, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        PERIOD_I = 8'd99; HOLDOFF_I = '0;
        for (int d = 0; d <= 200; d++) begin
            ENABLE_I = 1'b1;
            PULSE_I  = (d <= 100) || d == 110 || d == 150 || d == 200;
            @(negedge clk);
            n_cmp++;
            if ({VALID_O, OVERFLOW_O, COUNT_O} !== {m_valid, m_ovf, m_count}) begin
                n_bad++;
                $display("FAIL sat_model d=%0d: got v=%b o=%b c=%0d, want v=%b o=%b c=%0d",
                         d, VALID_O, OVERFLOW_O, COUNT_O, m_valid, m_ovf, m_count);
            end
            if (d == 100) begin
                n_cmp++;
                if ({VALID_O, OVERFLOW_O, COUNT_O} !== {1'b1, 1'b1, 4'd15}) begin
                    n_bad++;
                    $display("FAIL sat_full: got v=%b o=%b c=%0d, want v=1 o=1 c=15",
                             VALID_O, OVERFLOW_O, COUNT_O);
                end
            end else if (d == 200) begin
                n_cmp++;
                if ({VALID_O, OVERFLOW_O, COUNT_O} !== {1'b1, 1'b0, 4'd3}) begin
                    n_bad++;
                    $display("FAIL sat_next: got v=%b o=%b c=%0d, want v=1 o=0 c=3",
                             VALID_O, OVERFLOW_O, COUNT_O);
                end
            end else if (d > 100) begin
                n_cmp++;
                if (VALID_O !== 1'b0 || OVERFLOW_O !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sat_hold d=%0d: got v=%b o=%b, want v=0 o=1",
                             d, VALID_O, OVERFLOW_O);
                end
            end
        end
    endtask

    task automatic test_period_change();
        int   sum = 0;
        logic p;
        HOLDOFF_I = '0;
        for (int d = 0; d <= 30; d++) begin
            p = 1'($urandom_range(1, 0));
            ENABLE_I = 1'b1; PULSE_I = p;
            PERIOD_I = (d < 5) ? 8'd9 : 8'd0;
            if (d >= 1 && d <= 10) sum += int'(p);
            @(negedge clk);
            n_cmp++;
            if ({VALID_O, OVERFLOW_O, COUNT_O} !== {m_valid, m_ovf, m_count}) begin
                n_bad++;
                $display("FAIL period_model d=%0d: got v=%b o=%b c=%0d, want v=%b o=%b c=%0d",
                         d, VALID_O, OVERFLOW_O, COUNT_O, m_valid, m_ovf, m_count);
            end
            n_cmp++;
            if (d < 10 && VALID_O !== 1'b0) begin
                n_bad++;
                $display("FAIL period_early d=%0d: got v=%b, want v=0", d, VALID_O);
            end else if (d == 10 && (VALID_O !== 1'b1 || COUNT_O !== 4'(sum))) begin
                n_bad++;
                $display("FAIL period_first: got v=%b c=%0d, want v=1 c=%0d", VALID_O, COUNT_O, sum);
            end else if (d > 10 && (VALID_O !== 1'b1 || COUNT_O !== {3'b000, p})) begin
                n_bad++;
                $display("FAIL period_echo d=%0d: got v=%b c=%0d, want v=1 c=%0d",
                         d, VALID_O, COUNT_O, p);
            end
        end
    endtask

    task automatic test_abort();
        int   sum = 0;
        logic p;
        PERIOD_I = 8'd9; HOLDOFF_I = '0;
        for (int d = 0; d <= 22; d++) begin
            // Pulses before re-entry (and on the re-entry cycle) must not be counted.
            p = (d <= 8) ? 1'b1 : 1'($urandom_range(1, 0));
            ENABLE_I = !(d >= 5 && d <= 7); PULSE_I = p;
            if (d >= 9 && d <= 18) sum += int'(p);
            @(negedge clk);
            n_cmp++;
            if ({VALID_O, OVERFLOW_O, COUNT_O} !== {m_valid, m_ovf, m_count}) begin
                n_bad++;
                $display("FAIL abort_model d=%0d: got v=%b o=%b c=%0d, want v=%b o=%b c=%0d",
                         d, VALID_O, OVERFLOW_O, COUNT_O, m_valid, m_ovf, m_count);
            end
            n_cmp++;
            if (d != 18 && VALID_O !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_nostrobe d=%0d: got v=%b, want v=0", d, VALID_O);
            end else if (d == 18 && (VALID_O !== 1'b1 || COUNT_O !== 4'(sum))) begin
                n_bad++;
                $display("FAIL abort_reentry: got v=%b c=%0d, want v=1 c=%0d", VALID_O, COUNT_O, sum);
            end
        end
    endtask

    task automatic test_holdoff();
        PERIOD_I = 8'd9; HOLDOFF_I = 4'd3;
        for (int d = 0; d <= 10; d++) begin
            ENABLE_I = 1'b1; PULSE_I = (d >= 1);
            @(negedge clk);
            n_cmp++;
            if ({VALID_O, OVERFLOW_O, COUNT_O} !== {m_valid, m_ovf, m_count}) begin
                n_bad++;
                $display("FAIL holdoff_model d=%0d: got v=%b o=%b c=%0d, want v=%b o=%b c=%0d",
                         d, VALID_O, OVERFLOW_O, COUNT_O, m_valid, m_ovf, m_count);
            end
        end
        n_cmp++;
        if (VALID_O !== 1'b1 || COUNT_O !== 4'(HoldExp)) begin
            n_bad++;
            $display("FAIL holdoff_count: got v=%b c=%0d, want v=1 c=%0d", VALID_O, COUNT_O, HoldExp);
        end
    endtask

    task automatic test_reset_mid();
        PERIOD_I = 8'd4; HOLDOFF_I = '0;
        for (int d = 0; d <= 5; d++) begin
            ENABLE_I = 1'b1; PULSE_I = 1'b1; RST = (d == 5);
            @(negedge clk);
        end
        // RST landed on the terminal cycle: the strobe it would have produced is dropped.
        n_cmp++;
        if ({VALID_O, OVERFLOW_O, COUNT_O} !== {1'b0, 1'b0, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_mid: got v=%b o=%b c=%0d, want v=0 o=0 c=0",
                     VALID_O, OVERFLOW_O, COUNT_O);
        end
        RST = 1'b0;
    endtask

    task automatic test_random();
        for (int d = 0; d < 800; d++) begin
            RST       = ($urandom_range(149, 0) == 0);
            ENABLE_I  = ($urandom_range(24, 0) != 0);
            PULSE_I   = ($urandom_range(3, 0) != 0);
            HOLDOFF_I = 4'($urandom_range(3, 0));
            if ($urandom_range(15, 0) == 0) PERIOD_I = 8'($urandom_range(20, 0));
            @(negedge clk);
            n_cmp++;
            if ({VALID_O, OVERFLOW_O, COUNT_O} !== {m_valid, m_ovf, m_count}) begin
                n_bad++;
                $display("FAIL random d=%0d: got v=%b o=%b c=%0d, want v=%b o=%b c=%0d",
                         d, VALID_O, OVERFLOW_O, COUNT_O, m_valid, m_ovf, m_count);
            end
        end
    endtask

    initial begin
        RST = 1'b1; ENABLE_I = 1'b0; PULSE_I = 1'b0;
        PERIOD_I = '0; HOLDOFF_I = '0;
        test_reset();
        test_basic();
        go_idle();
        test_saturation();
        go_idle();
        test_period_change();
        go_idle();
        test_abort();
        go_idle();
        test_holdoff();
        go_idle();
        test_reset_mid();
        go_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
